refill_dispatcher: RTL and testbench
====================================

Name: refill_dispatcher

Overview:
- Sits directly downstream of memory_controller.
- Captures the miss address at miss start and waits for the completed 320-bit refill block.
- Writes the block plus its tag into the direct-mapped cache data/tag array in one cycle.
- Then returns the requested 32-bit word to the user port with a valid/ready handshake, and signals the control unit when the refill is finished.

Parameters:
- ADDR_WIDTH, 8: block address width; index = low INDEX_WIDTH bits, tag = remaining high bits.
- INDEX_WIDTH, 4: cache set index width (16 sets).
- MEM_DATA_WIDTH, 32: word width.
- WORDS_PER_BLOCK, 10: words per block; block width = 320 (derived localparam).
- OFFSET_WIDTH, 4: word-offset width.

Ports:
- clk  in  1  clock
- arst_n  in  1  reset, asynchronous, active-low
- i_halt  in  1  global stall; freezes all state
- i_miss_block_addr  in  ADDR_WIDTH  block address of the miss
- i_miss_word_offset  in  OFFSET_WIDTH  requested word within the block
- i_miss_valid  in  1  miss request valid
- o_miss_ready  out  1  block can accept a miss
- i_mem_block_data  in  320  assembled block from memory_controller
- i_mem_data_received  in  1  single-cycle pulse: block complete
- o_arr_wr_en  out  1  array write strobe
- o_arr_wr_index  out  INDEX_WIDTH  array set index
- o_arr_wr_tag  out  ADDR_WIDTH-INDEX_WIDTH  tag to write
- o_arr_wr_data  out  320  block to write
- o_user_data  out  MEM_DATA_WIDTH  requested word
- o_user_data_valid  out  1  user word valid
- i_user_ready  in  1  user accepts word
- o_offset_err  out  1  requested offset ≥ WORDS_PER_BLOCK; qualified by o_user_data_valid
- o_refill_done  out  1  single-cycle pulse to control unit

Behaviour:

Reset:
- State returns to IDLE.
- Address, offset and block registers clear to 0.
- All outputs are 0 except o_miss_ready, which is 1 once reset is released.

States: IDLE, WAIT_DATA, WRITE, RESPOND.
- IDLE:
  - o_miss_ready = ~i_halt.
  - On i_miss_valid & o_miss_ready: capture address and offset, go to WAIT_DATA.
  - i_mem_data_received in IDLE is ignored; no write occurs.
- WAIT_DATA:
  - On i_mem_data_received & ~i_halt: capture i_mem_block_data into the block register, go to WRITE.
  - A new i_miss_valid is not accepted (o_miss_ready = 0).
- WRITE (exactly one cycle):
  - o_arr_wr_en = ~i_halt.
  - index = addr[INDEX_WIDTH-1:0]; tag = addr[ADDR_WIDTH-1:INDEX_WIDTH]; data = block register.
  - Go to RESPOND.
- RESPOND:
  - o_user_data_valid = 1.
  - o_user_data = word[offset], selected by an explicit case mux (no multiplier). Word 0 = bits 31:0; word 9 = bits 319:288.
  - If offset ≥ 10: o_user_data = 0 and o_offset_err = 1.
  - Data is held stable until i_user_ready.
  - On i_user_ready & ~i_halt: o_refill_done pulses for that same cycle; go to IDLE.

Latency: i_mem_data_received in cycle N gives o_arr_wr_en in N+1 and o_user_data_valid from N+2.

Halt:
- No state, register or handshake advances.
- o_arr_wr_en, o_refill_done and o_miss_ready are forced to 0.
- o_user_data_valid and o_user_data hold their value.

Other boundary rules:
- i_mem_data_received while halted is lost. Upstream guarantees it is not asserted under halt.
- Reset mid-operation: any pending write or response is abandoned with no partial array write.
- Outputs other than the handshake/strobe outputs are registered. o_arr_wr_en, o_refill_done and o_miss_ready decode from the state register and i_halt.

Decomposition:
- Shared package/include:
  - state encodings (2-bit);
  - ADDR_WIDTH, MEM_DATA_WIDTH, WORDS_PER_BLOCK, the 320 block width;
  - INDEX_WIDTH and tag width, shared with memory_controller and the tag array.
- One natural sub-module, block_word_select: combinational 320→32 case mux plus offset-range check, reusable by the hit path.

Test Plan:
- Basic refill: miss addr 0x5A, offset 3; block word k = 0x1000_0000+k; pulse received → o_arr_wr_en one cycle, index 0xA, tag 0x5, data = block; next cycle o_user_data = 0x1000_0003, valid, with i_user_ready=1 → o_refill_done pulse, o_miss_ready=1.
- Offset extremes: offsets 0 and 9 on the same block → 0x1000_0000 and 0x1000_0009. Offset 12 → o_user_data 0, o_offset_err 1, array still written.
- Backpressure: i_user_ready low for 5 cycles in RESPOND → o_user_data stable and valid for all 5 cycles, no done pulse, o_miss_ready 0; raise ready → done pulse.
- Halt: i_halt high during WRITE for 3 cycles → o_arr_wr_en 0 throughout, then exactly one write cycle after release. Halt in IDLE with i_miss_valid → miss not captured.
- Spurious/overlap: i_mem_data_received pulse in IDLE → no write, stays IDLE. Second i_miss_valid during WAIT_DATA → ignored; the first address is written.
- Reset mid-op: assert arst_n low in WRITE → o_arr_wr_en 0 immediately, all outputs 0; after release a fresh miss (addr 0x03, offset 1) completes normally.

Source files
------------

// File: rtl/refill_dispatcher_pkg.sv
`default_nettype none
// ============================================================================
// Module  : refill_dispatcher_pkg
// Brief   : Shared widths and state encodings for the cache refill path.
// Revision: 1.0 - initial release
// ============================================================================
package refill_dispatcher_pkg;

    localparam int ADDR_WIDTH      = 8;
    localparam int INDEX_WIDTH     = 4;
    localparam int TAG_WIDTH       = ADDR_WIDTH - INDEX_WIDTH;
    localparam int MEM_DATA_WIDTH  = 32;
    localparam int WORDS_PER_BLOCK = 10;
    localparam int BLOCK_WIDTH     = MEM_DATA_WIDTH * WORDS_PER_BLOCK;
    localparam int OFFSET_WIDTH    = 4;

    localparam int STATE_WIDTH = 2;
    localparam logic [STATE_WIDTH-1:0] ST_IDLE      = 2'd0;
    localparam logic [STATE_WIDTH-1:0] ST_WAIT_DATA = 2'd1;
    localparam logic [STATE_WIDTH-1:0] ST_WRITE     = 2'd2;
    localparam logic [STATE_WIDTH-1:0] ST_RESPOND   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/refill_dispatcher_block_word_select.sv
`default_nettype none
// ============================================================================
// Module  : block_word_select
// Brief   : Picks one 32-bit word out of a 10-word block and flags offsets
//           that fall past the end of the block. Purely combinational.
// Revision: 1.0 - initial release
// ============================================================================
module block_word_select #(
    parameter int MEM_DATA_WIDTH  = refill_dispatcher_pkg::MEM_DATA_WIDTH,
    parameter int WORDS_PER_BLOCK = refill_dispatcher_pkg::WORDS_PER_BLOCK,
    parameter int OFFSET_WIDTH    = refill_dispatcher_pkg::OFFSET_WIDTH
) (
    input  logic [MEM_DATA_WIDTH*WORDS_PER_BLOCK-1:0] i_block,
    input  logic [OFFSET_WIDTH-1:0]                   i_offset,
    output logic [MEM_DATA_WIDTH-1:0]                 o_word,
    output logic                                      o_offset_err
);
    import refill_dispatcher_pkg::*;

    // Fixed-slice case mux keeps the select free of any offset multiplier.
    always_comb begin
        o_word = '0;
        case (i_offset)
            OFFSET_WIDTH'(0): o_word = i_block[0*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
            OFFSET_WIDTH'(1): o_word = i_block[1*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
            OFFSET_WIDTH'(2): o_word = i_block[2*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
            OFFSET_WIDTH'(3): o_word = i_block[3*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
            OFFSET_WIDTH'(4): o_word = i_block[4*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
            OFFSET_WIDTH'(5): o_word = i_block[5*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
            OFFSET_WIDTH'(6): o_word = i_block[6*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
            OFFSET_WIDTH'(7): o_word = i_block[7*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
            OFFSET_WIDTH'(8): o_word = i_block[8*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
            OFFSET_WIDTH'(9): o_word = i_block[9*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
            default:          o_word = '0;
        endcase
    end

    assign o_offset_err = (i_offset >= OFFSET_WIDTH'(WORDS_PER_BLOCK));

endmodule
`default_nettype wire

// File: rtl/refill_dispatcher.sv
`default_nettype none
// ============================================================================
// Module  : refill_dispatcher
// Brief   : Captures a miss, waits for the refill block, writes it into the
//           data/tag array and returns the requested word to the user port.
// Revision: 1.0 - initial release
// ============================================================================
module refill_dispatcher #(
    parameter int ADDR_WIDTH      = refill_dispatcher_pkg::ADDR_WIDTH,
    parameter int INDEX_WIDTH     = refill_dispatcher_pkg::INDEX_WIDTH,
    parameter int MEM_DATA_WIDTH  = refill_dispatcher_pkg::MEM_DATA_WIDTH,
    parameter int WORDS_PER_BLOCK = refill_dispatcher_pkg::WORDS_PER_BLOCK,
    parameter int OFFSET_WIDTH    = refill_dispatcher_pkg::OFFSET_WIDTH
) (
    input  logic                                      clk,
    input  logic                                      arst_n,
    input  logic                                      i_halt,
    input  logic [ADDR_WIDTH-1:0]                     i_miss_block_addr,
    input  logic [OFFSET_WIDTH-1:0]                   i_miss_word_offset,
    input  logic                                      i_miss_valid,
    output logic                                      o_miss_ready,
    input  logic [MEM_DATA_WIDTH*WORDS_PER_BLOCK-1:0] i_mem_block_data,
    input  logic                                      i_mem_data_received,
    output logic                                      o_arr_wr_en,
    output logic [INDEX_WIDTH-1:0]                    o_arr_wr_index,
    output logic [ADDR_WIDTH-INDEX_WIDTH-1:0]         o_arr_wr_tag,
    output logic [MEM_DATA_WIDTH*WORDS_PER_BLOCK-1:0] o_arr_wr_data,
    output logic [MEM_DATA_WIDTH-1:0]                 o_user_data,
    output logic                                      o_user_data_valid,
    input  logic                                      i_user_ready,
    output logic                                      o_offset_err,
    output logic                                      o_refill_done
);
    import refill_dispatcher_pkg::*;

    localparam int c_block_width = MEM_DATA_WIDTH * WORDS_PER_BLOCK;

    logic [STATE_WIDTH-1:0]    r_state;
    logic [STATE_WIDTH-1:0]    w_next_state;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [OFFSET_WIDTH-1:0]   r_offset;
    logic [c_block_width-1:0]  r_block;
    logic [MEM_DATA_WIDTH-1:0] r_user_data;
    logic                      r_user_valid;
    logic                      r_offset_err;
    logic [MEM_DATA_WIDTH-1:0] w_sel_word;
    logic                      w_sel_err;
    logic                      w_miss_ready;
    logic                      w_wr_en;
    logic                      w_done;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Halt freezes the FSM wherever it is.
    always_comb begin
        w_next_state = r_state;
        if (!i_halt) begin
            case (r_state)
                ST_IDLE:      if (i_miss_valid)        w_next_state = ST_WAIT_DATA;
                ST_WAIT_DATA: if (i_mem_data_received) w_next_state = ST_WRITE;
                ST_WRITE:                              w_next_state = ST_RESPOND;
                ST_RESPOND:   if (i_user_ready)        w_next_state = ST_IDLE;
                default:                               w_next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_miss_ready = 1'b0;
        w_wr_en      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE:    w_miss_ready = ~i_halt;
            ST_WRITE:   w_wr_en      = ~i_halt;
            ST_RESPOND: w_done       = i_user_ready & ~i_halt;
            default:    ;
        endcase
    end

    block_word_select #(
        .MEM_DATA_WIDTH  (MEM_DATA_WIDTH),
        .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
        .OFFSET_WIDTH    (OFFSET_WIDTH)
    ) u_word_select (
        .i_block      (r_block),
        .i_offset     (r_offset),
        .o_word       (w_sel_word),
        .o_offset_err (w_sel_err)
    );

    // The user word is loaded while the array is written so it is ready the
    // cycle after the write strobe.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_addr       <= '0;
            r_offset     <= '0;
            r_block      <= '0;
            r_user_data  <= '0;
            r_user_valid <= 1'b0;
            r_offset_err <= 1'b0;
        end else if (!i_halt) begin
            if (w_miss_ready && i_miss_valid) begin
                r_addr   <= i_miss_block_addr;
                r_offset <= i_miss_word_offset;
            end
            if ((r_state == ST_WAIT_DATA) && i_mem_data_received) begin
                r_block <= i_mem_block_data;
            end
            if (r_state == ST_WRITE) begin
                r_user_data  <= w_sel_word;
                r_offset_err <= w_sel_err;
                r_user_valid <= 1'b1;
            end
            if (w_done) begin
                r_user_data  <= '0;
                r_offset_err <= 1'b0;
                r_user_valid <= 1'b0;
            end
        end
    end

    assign o_miss_ready      = w_miss_ready;
    assign o_arr_wr_en       = w_wr_en;
    assign o_refill_done     = w_done;
    assign o_arr_wr_index    = r_addr[INDEX_WIDTH-1:0];
    assign o_arr_wr_tag      = r_addr[ADDR_WIDTH-1:INDEX_WIDTH];
    assign o_arr_wr_data     = r_block;
    assign o_user_data       = r_user_data;
    assign o_user_data_valid = r_user_valid;
    assign o_offset_err      = r_offset_err;

endmodule
`default_nettype wire

// File: tb/tb_refill_dispatcher.sv
`default_nettype none
// ============================================================================
// Module  : tb_refill_dispatcher
// Brief   : Self-checking bench for refill_dispatcher: directed refills plus
//           randomized refills checked against a transaction-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_refill_dispatcher;
    import refill_dispatcher_pkg::*;

    logic                       clk;
    logic                       arst_n;
    logic                       i_halt;
    logic [ADDR_WIDTH-1:0]      i_miss_block_addr;
    logic [OFFSET_WIDTH-1:0]    i_miss_word_offset;
    logic                       i_miss_valid;
    logic                       o_miss_ready;
    logic [BLOCK_WIDTH-1:0]     i_mem_block_data;
    logic                       i_mem_data_received;
    logic                       o_arr_wr_en;
    logic [INDEX_WIDTH-1:0]     o_arr_wr_index;
    logic [TAG_WIDTH-1:0]       o_arr_wr_tag;
    logic [BLOCK_WIDTH-1:0]     o_arr_wr_data;
    logic [MEM_DATA_WIDTH-1:0]  o_user_data;
    logic                       o_user_data_valid;
    logic                       i_user_ready;
    logic                       o_offset_err;
    logic                       o_refill_done;

    int n_cmp = 0;
    int n_err = 0;

    refill_dispatcher dut (
        .clk                 (clk),
        .arst_n              (arst_n),
        .i_halt              (i_halt),
        .i_miss_block_addr   (i_miss_block_addr),
        .i_miss_word_offset  (i_miss_word_offset),
        .i_miss_valid        (i_miss_valid),
        .o_miss_ready        (o_miss_ready),
        .i_mem_block_data    (i_mem_block_data),
        .i_mem_data_received (i_mem_data_received),
        .o_arr_wr_en         (o_arr_wr_en),
        .o_arr_wr_index      (o_arr_wr_index),
        .o_arr_wr_tag        (o_arr_wr_tag),
        .o_arr_wr_data       (o_arr_wr_data),
        .o_user_data         (o_user_data),
        .o_user_data_valid   (o_user_data_valid),
        .i_user_ready        (i_user_ready),
        .o_offset_err        (o_offset_err),
        .o_refill_done       (o_refill_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [BLOCK_WIDTH-1:0] obs,
                        input logic [BLOCK_WIDTH-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BLOCK_WIDTH-1:0] rand_block();
        logic [BLOCK_WIDTH-1:0] b;
        for (int k = 0; k < WORDS_PER_BLOCK; k++)
            b[k*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = $urandom;
        return b;
    endfunction

    // One complete miss/refill/response transaction, checked against the
    // expected outcome computed from the address, offset and block alone.
    task automatic refill(input logic [ADDR_WIDTH-1:0] addr, input logic [OFFSET_WIDTH-1:0] off,
                          input logic [BLOCK_WIDTH-1:0] blk, input int wait_cyc,
                          input int halt_cyc, input int bp_cyc, input bit stray_miss);
        logic [MEM_DATA_WIDTH-1:0] exp_word;
        logic                      exp_err;
        int                        exp_index;
        int                        exp_tag;
        bit                        halted;
        exp_err   = (int'(off) >= WORDS_PER_BLOCK);
        exp_word  = exp_err ? '0 : blk[int'(off)*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
        exp_index = int'(addr) % (1 << INDEX_WIDTH);
        exp_tag   = int'(addr) / (1 << INDEX_WIDTH);

        i_miss_block_addr  = addr;
        i_miss_word_offset = off;
        i_miss_valid       = 1'b1;
        #1;
        chk1("miss_ready_idle", o_miss_ready, 1'b1);
        tick();
        i_miss_valid       = stray_miss;
        i_miss_block_addr  = ~addr;
        i_miss_word_offset = off + 4'd1;
        for (int k = 0; k < wait_cyc; k++) begin
            #1;
            chk1("wait_miss_ready", o_miss_ready, 1'b0);
            chk1("wait_wr_en", o_arr_wr_en, 1'b0);
            tick();
        end
        i_mem_block_data    = blk;
        i_mem_data_received = 1'b1;
        #1;
        chk1("recv_wr_en", o_arr_wr_en, 1'b0);
        tick();
        i_mem_data_received = 1'b0;
        i_miss_valid        = 1'b0;
        i_mem_block_data    = rand_block();
        if (halt_cyc > 0) begin
            i_halt = 1'b1;
            for (int k = 0; k < halt_cyc; k++) begin
                #1;
                chk1("halt_write_wr_en", o_arr_wr_en, 1'b0);
                tick();
            end
            i_halt = 1'b0;
        end
        #1;
        chk1("write_wr_en", o_arr_wr_en, 1'b1);
        chkv("write_index", BLOCK_WIDTH'(o_arr_wr_index), BLOCK_WIDTH'(exp_index));
        chkv("write_tag", BLOCK_WIDTH'(o_arr_wr_tag), BLOCK_WIDTH'(exp_tag));
        chkv("write_data", o_arr_wr_data, blk);
        chk1("write_valid", o_user_data_valid, 1'b0);
        tick();
        chk1("after_write_wr_en", o_arr_wr_en, 1'b0);
        for (int k = 0; k < bp_cyc; k++) begin
            halted       = ($urandom_range(0, 2) == 0);
            i_halt       = halted;
            i_user_ready = halted ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            chk1("bp_valid", o_user_data_valid, 1'b1);
            chkv("bp_data", BLOCK_WIDTH'(o_user_data), BLOCK_WIDTH'(exp_word));
            chk1("bp_err", o_offset_err, exp_err);
            chk1("bp_done", o_refill_done, 1'b0);
            chk1("bp_miss_ready", o_miss_ready, 1'b0);
            tick();
        end
        i_halt       = 1'b0;
        i_user_ready = 1'b1;
        #1;
        chk1("resp_valid", o_user_data_valid, 1'b1);
        chkv("resp_data", BLOCK_WIDTH'(o_user_data), BLOCK_WIDTH'(exp_word));
        chk1("resp_err", o_offset_err, exp_err);
        chk1("resp_done", o_refill_done, 1'b1);
        tick();
        i_user_ready = 1'b0;
        #1;
        chk1("end_done", o_refill_done, 1'b0);
        chk1("end_valid", o_user_data_valid, 1'b0);
        chk1("end_miss_ready", o_miss_ready, 1'b1);
    endtask

    initial begin
        logic [BLOCK_WIDTH-1:0] blk;
        arst_n              = 1'b0;
        i_halt              = 1'b0;
        i_miss_block_addr   = '0;
        i_miss_word_offset  = '0;
        i_miss_valid        = 1'b0;
        i_mem_block_data    = '0;
        i_mem_data_received = 1'b0;
        i_user_ready        = 1'b0;
        #3;
        chk1("rst_wr_en", o_arr_wr_en, 1'b0);
        chk1("rst_valid", o_user_data_valid, 1'b0);
        chk1("rst_done", o_refill_done, 1'b0);
        chk1("rst_err", o_offset_err, 1'b0);
        chkv("rst_user_data", BLOCK_WIDTH'(o_user_data), '0);
        chkv("rst_wr_data", o_arr_wr_data, '0);
        tick();
        tick();
        arst_n = 1'b1;
        #1;
        chk1("post_rst_miss_ready", o_miss_ready, 1'b1);
        tick();

        // Directed refills on the counting block.
        for (int k = 0; k < WORDS_PER_BLOCK; k++)
            blk[k*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = 32'h1000_0000 + k;
        refill(8'h5A, 4'd3, blk, 0, 0, 0, 1'b0);
        refill(8'h5A, 4'd0, blk, 1, 0, 0, 1'b0);
        refill(8'h5A, 4'd9, blk, 0, 0, 0, 1'b0);
        refill(8'h21, 4'd12, blk, 0, 0, 0, 1'b0);
        refill(8'hC7, 4'd5, blk, 2, 0, 5, 1'b0);
        refill(8'h3E, 4'd7, blk, 0, 3, 0, 1'b0);
        refill(8'h94, 4'd2, blk, 2, 0, 0, 1'b1);

        // Halted miss in IDLE is not captured.
        i_halt            = 1'b1;
        i_miss_valid      = 1'b1;
        i_miss_block_addr = 8'hFF;
        #1;
        chk1("halt_idle_miss_ready", o_miss_ready, 1'b0);
        tick();
        i_halt       = 1'b0;
        i_miss_valid = 1'b0;
        #1;
        chk1("halt_idle_stays_idle", o_miss_ready, 1'b1);

        // Stray completion pulse in IDLE.
        i_mem_data_received = 1'b1;
        i_mem_block_data    = rand_block();
        #1;
        chk1("stray_recv_wr_en", o_arr_wr_en, 1'b0);
        tick();
        i_mem_data_received = 1'b0;
        #1;
        chk1("stray_recv_no_write", o_arr_wr_en, 1'b0);
        chk1("stray_recv_idle", o_miss_ready, 1'b1);

        // Reset while the write is pending.
        i_miss_block_addr  = 8'hB6;
        i_miss_word_offset = 4'd4;
        i_miss_valid       = 1'b1;
        tick();
        i_miss_valid        = 1'b0;
        i_mem_block_data    = rand_block();
        i_mem_data_received = 1'b1;
        tick();
        i_mem_data_received = 1'b0;
        #1;
        chk1("pre_rst_wr_en", o_arr_wr_en, 1'b1);
        arst_n = 1'b0;
        #1;
        chk1("midrst_wr_en", o_arr_wr_en, 1'b0);
        chk1("midrst_valid", o_user_data_valid, 1'b0);
        chk1("midrst_done", o_refill_done, 1'b0);
        chkv("midrst_wr_data", o_arr_wr_data, '0);
        chkv("midrst_index", BLOCK_WIDTH'(o_arr_wr_index), '0);
        chkv("midrst_tag", BLOCK_WIDTH'(o_arr_wr_tag), '0);
        tick();
        #1;
        chk1("midrst_held_wr_en", o_arr_wr_en, 1'b0);
        arst_n = 1'b1;
        tick();
        refill(8'h03, 4'd1, blk, 0, 0, 0, 1'b0);

        // Randomized refills.
        for (int n = 0; n < 40; n++) begin
            refill(ADDR_WIDTH'($urandom), OFFSET_WIDTH'($urandom_range(0, 15)), rand_block(),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
